// File: rtl/heart_pkg.sv
// heart_pkg: shared types and constants for the heart-pattern envelope detector.
//   env_state_t : tracking state (SEEK, POS, NEG)
//   SAMPLE_ZERO : offset-binary code for a zero sample
//   MAG_MAX     : largest representable envelope magnitude
//   to_signed() : offset-binary to two's-complement conversion
package heart_pkg;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } env_state_t;

  localparam logic [15:0] SAMPLE_ZERO = 16'h8000;
  localparam logic [15:0] MAG_MAX     = 16'd32767;

  // Flipping the MSB of an offset-binary code gives the two's-complement value.
  function automatic logic signed [15:0] to_signed(input logic [15:0] x);
    return signed'(x ^ SAMPLE_ZERO);
  endfunction

endpackage

// File: rtl/heart_env_detector_if.sv
// heart_env_detector_if: sample stream in, recovered envelope/period out.
//   sample_valid, sample            : offset-binary sample stream (source side)
//   env_up, env_down, period        : per-cycle results
//   env_valid                       : one-cycle pulse when results update
//   locked                          : carrier tracking stable
// Modports: master = sample source / result consumer, slave = detector.
interface heart_env_detector_if #(
  parameter int PERIOD_W = 14
) ();

  logic                sample_valid;
  logic [15:0]         sample;
  logic [15:0]         env_up;
  logic [15:0]         env_down;
  logic [PERIOD_W-1:0] period;
  logic                env_valid;
  logic                locked;

  modport master (
    output sample_valid, sample,
    input  env_up, env_down, period, env_valid, locked
  );

  modport slave (
    input  sample_valid, sample,
    output env_up, env_down, period, env_valid, locked
  );

endinterface

// File: rtl/heart_peak_hold.sv
// heart_peak_hold: signed running extremum tracker.
//   MAX_MODE = 1 tracks the maximum, 0 tracks the minimum.
//   clk  : clock
//   en   : sample qualifier; nothing changes while low
//   load : restart the extremum at din (takes effect only with en)
//   clr  : force the held value to zero
//   din  : signed sample
//   q    : held extremum
// The held value is datapath only and carries no reset; it is always
// loaded before the surrounding control logic consumes it.
module heart_peak_hold #(
  parameter bit MAX_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               en,
  input  logic               load,
  input  logic               clr,
  input  logic signed [15:0] din,
  output logic signed [15:0] q
);

  logic better;

  assign better = MAX_MODE ? (din > q) : (din < q);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      if (load || better) begin
        q <= din;
      end
    end
  end

endmodule

// File: rtl/heart_env_detector.sv
// heart_env_detector: recovers the upper/lower envelope and the carrier
// period from an offset-binary DDS sample stream, one result per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : heart_env_detector_if.slave (sample_valid/sample in;
//           env_up/env_down/period/env_valid/locked out)
// Optional feature macro: HEART_ENV_SMOOTH_EN enables first-order IIR
// smoothing of env_up/env_down once lock is established.
module heart_env_detector
  import heart_pkg::*;
#(
  parameter int HYST         = 64,
  parameter int PERIOD_W     = 14,
  parameter int MIN_PERIOD   = 16,
  parameter int MAX_PERIOD   = 16383,
  parameter int LOCK_CYCLES  = 4,
  parameter int SMOOTH_SHIFT = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  heart_env_detector_if.slave  bus
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic signed [15:0]   HYST_P  = 16'(HYST);
  localparam logic signed [15:0]   HYST_N  = 16'(-HYST);
  localparam logic [PERIOD_W:0]    MAX_CNT = (PERIOD_W + 1)'(MAX_PERIOD);
  localparam logic [PERIOD_W:0]    MIN_CNT = (PERIOD_W + 1)'(MIN_PERIOD);
  localparam logic [LOCK_W-1:0]    LOCK_N  = LOCK_W'(LOCK_CYCLES);

  env_state_t          state;
  logic [PERIOD_W-1:0] cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [LOCK_W-1:0]   lock_cnt_nxt;
  logic signed [15:0]  up_lat;

  logic [15:0]         env_up_r;
  logic [15:0]         env_down_r;
  logic [PERIOD_W-1:0] period_r;
  logic                env_valid_r;
  logic                locked_r;

  logic signed [15:0]  s;
  logic                vld;
  logic                above;
  logic                below;
  logic [PERIOD_W:0]   cnt_inc;
  logic                tmo_hit;
  logic                in_range;
  logic                max_load;
  logic                min_load;
  logic                tmo;
  logic signed [15:0]  maxv;
  logic signed [15:0]  minv;
  logic [15:0]         up_new;
  logic [15:0]         down_new;

  // Positive envelope never goes below zero.
  function automatic logic [15:0] clamp_up(input logic signed [15:0] v);
    return (v < 0) ? 16'd0 : 16'(v);
  endfunction

  // Magnitude of a negative peak; -32768 has no positive twin and saturates.
  function automatic logic [15:0] sat_mag(input logic signed [15:0] v);
    if (v == -16'sd32768) return MAG_MAX;
    if (v > 0)            return 16'd0;
    return 16'(-v);
  endfunction

`ifdef HEART_ENV_SMOOTH_EN
  // env + ((new - env) >>> SMOOTH_SHIFT) with a 17-bit signed difference.
  function automatic logic [15:0] smooth(input logic [15:0] old_v,
                                         input logic [15:0] new_v);
    logic signed [16:0] d;
    d = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
    d = d >>> SMOOTH_SHIFT;
    return 16'($signed({1'b0, old_v}) + d);
  endfunction
`else
  logic unused_smooth_shift;
  assign unused_smooth_shift = ^SMOOTH_SHIFT;
`endif

  assign s       = to_signed(bus.sample);
  assign vld     = bus.sample_valid;
  assign above   = s > HYST_P;
  assign below   = s < HYST_N;
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign tmo_hit = cnt_inc >= MAX_CNT;

  assign in_range = ({1'b0, cnt} >= MIN_CNT) && ({1'b0, cnt} <= MAX_CNT);

  // A new positive half-cycle restarts the maximum; entering NEG restarts the minimum.
  assign max_load = vld && above && ((state == SEEK) || (state == NEG));
  assign min_load = vld && below && (state == POS);
  assign tmo      = vld && tmo_hit &&
                    (((state == POS) && !below) || ((state == NEG) && !above));

  assign up_new   = clamp_up(up_lat);
  assign down_new = sat_mag(minv);

  assign lock_cnt_nxt = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + 1'b1;

  heart_peak_hold #(.MAX_MODE(1'b1)) u_max (
    .clk  (clk),
    .en   (vld),
    .load (max_load),
    .clr  (tmo),
    .din  (s),
    .q    (maxv)
  );

  heart_peak_hold #(.MAX_MODE(1'b0)) u_min (
    .clk  (clk),
    .en   (vld),
    .load (min_load),
    .clr  (tmo),
    .din  (s),
    .q    (minv)
  );

  // Tracking FSM; the sample is consumed this edge, results appear next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEEK;
      cnt         <= '0;
      lock_cnt    <= '0;
      up_lat      <= '0;
      env_up_r    <= '0;
      env_down_r  <= '0;
      period_r    <= '0;
      env_valid_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      env_valid_r <= 1'b0;
      if (vld) begin
        case (state)
          SEEK: begin
            if (above) begin
              state <= POS;
              cnt   <= PERIOD_W'(1);
            end
          end
          POS: begin
            if (below) begin
              state  <= NEG;
              up_lat <= maxv;
              cnt    <= cnt_inc[PERIOD_W-1:0];
            end else if (tmo_hit) begin
              state    <= SEEK;
              cnt      <= '0;
              lock_cnt <= '0;
              locked_r <= 1'b0;
            end else begin
              cnt <= cnt_inc[PERIOD_W-1:0];
            end
          end
          NEG: begin
            if (above) begin
              state <= POS;
              cnt   <= PERIOD_W'(1);
              if (in_range) begin
                env_valid_r <= 1'b1;
                period_r    <= cnt;
                lock_cnt    <= lock_cnt_nxt;
                locked_r    <= (lock_cnt_nxt == LOCK_N);
`ifdef HEART_ENV_SMOOTH_EN
                if (locked_r) begin
                  env_up_r   <= smooth(env_up_r, up_new);
                  env_down_r <= smooth(env_down_r, down_new);
                end else begin
                  env_up_r   <= up_new;
                  env_down_r <= down_new;
                end
`else
                env_up_r   <= up_new;
                env_down_r <= down_new;
`endif
              end else begin
                lock_cnt <= '0;
                locked_r <= 1'b0;
              end
            end else if (tmo_hit) begin
              state    <= SEEK;
              cnt      <= '0;
              lock_cnt <= '0;
              locked_r <= 1'b0;
            end else begin
              cnt <= cnt_inc[PERIOD_W-1:0];
            end
          end
          default: begin
            state <= SEEK;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.env_up    = env_up_r;
  assign bus.env_down  = env_down_r;
  assign bus.period    = period_r;
  assign bus.env_valid = env_valid_r;
  assign bus.locked    = locked_r;

endmodule

// File: tb/tb_heart_env_detector.sv
module tb_heart_env_detector;
  import heart_pkg::*;

  localparam int MAX_P = 16383;

  typedef struct {
    int pos_pk;
    int neg_pk;
    int npos;
    int nneg;
    int ncyc;
    int exp_up;
    int exp_down;
    int exp_period;
    int exp_lock;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  heart_env_detector_if #(.PERIOD_W(14)) bus ();

  heart_env_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.env_valid === 1'b1) pulses++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int v);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample       = 16'(v + 32768);
  endtask

  task automatic half(input int v, input int n);
    repeat (n) put(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample       = SAMPLE_ZERO;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic sine(input int first, input int last);
    real r;
    for (int i = first; i <= last; i++) begin
      r = 20000.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 100.0);
      put(int'(r));
    end
  endtask

  vec_t vecs[5];
  int p0;

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample       = SAMPLE_ZERO;

    vecs[0] = '{20000, -20000,  50,  50, 5, 20000, 20000, 100, 1};
    vecs[1] = '{30000, -12000, 100, 100, 4, 30000, 12000, 200, 1};
    vecs[2] = '{12000, -32768,  20,  20, 2, 12000, 32767,  40, 0};
    vecs[3] = '{   65,    -65,   8,   8, 3,    65,    65,  16, 0};
    vecs[4] = '{32767,   -100,  10,  30, 1, 32767,   100,  40, 0};

    // Reset state
    idle(3);
    chk("rst_env_up",    int'(bus.env_up),    0);
    chk("rst_env_down",  int'(bus.env_down),  0);
    chk("rst_period",    int'(bus.period),    0);
    chk("rst_env_valid", int'(bus.env_valid), 0);
    chk("rst_locked",    int'(bus.locked),    0);
    rst_n = 1'b1;
    idle(1);

    // Table-driven square-ish carriers
    for (int k = 0; k < 5; k++) begin
      do_reset();
      p0 = pulses;
      for (int c = 0; c < vecs[k].ncyc; c++) begin
        half(vecs[k].pos_pk, vecs[k].npos);
        half(vecs[k].neg_pk, vecs[k].nneg);
      end
      put(vecs[k].pos_pk);
      idle(2);
      chk($sformatf("vec%0d_pulses", k),   pulses - p0,          vecs[k].ncyc);
      chk($sformatf("vec%0d_env_up", k),   int'(bus.env_up),     vecs[k].exp_up);
      chk($sformatf("vec%0d_env_down", k), int'(bus.env_down),   vecs[k].exp_down);
      chk($sformatf("vec%0d_period", k),   int'(bus.period),     vecs[k].exp_period);
      chk($sformatf("vec%0d_locked", k),   int'(bus.locked),     vecs[k].exp_lock);
    end

    // Sine carrier, 100 samples/cycle, amplitude 20000
    do_reset();
    p0 = pulses;
    sine(1, 301);
    idle(2);
    chk("sine_pulses3", pulses - p0, 3);
    chk("sine_locked3", int'(bus.locked), 0);
    sine(302, 401);
    idle(2);
    chk("sine_pulses4", pulses - p0, 4);
    chk("sine_env_up",   int'(bus.env_up),   20000);
    chk("sine_env_down", int'(bus.env_down), 20000);
    chk("sine_period",   int'(bus.period),   100);
    chk("sine_locked4",  int'(bus.locked),   1);

    // Carrier stalls at +5000: cnt is 1 at the last POS entry
    half(5000, MAX_P - 2);
    idle(2);
    chk("tmo_pre_locked", int'(bus.locked), 1);
    chk("tmo_pre_state",  int'(dut.state),  int'(POS));
    put(5000);
    idle(2);
    chk("tmo_locked",   int'(bus.locked),   0);
    chk("tmo_state",    int'(dut.state),    int'(SEEK));
    chk("tmo_env_up",   int'(bus.env_up),   20000);
    chk("tmo_env_down", int'(bus.env_down), 20000);
    chk("tmo_period",   int'(bus.period),   100);
    chk("tmo_pulses",   pulses - p0,        4);

    // Noise inside the hysteresis band
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 50; i++) begin
      put(50); put(-50); put(64); put(-64);
    end
    idle(2);
    chk("noise_pulses", pulses - p0, 0);
    chk("noise_state",  int'(dut.state), int'(SEEK));

    // Lock on period-16 carrier, then a period-8 glitch
    do_reset();
    p0 = pulses;
    for (int c = 0; c < 4; c++) begin
      half(100, 8);
      half(-100, 8);
    end
    put(100);
    idle(2);
    chk("glitch_pre_locked", int'(bus.locked), 1);
    half(100, 3);
    half(-100, 4);
    put(100);
    idle(2);
    chk("glitch_pulses", pulses - p0, 4);
    chk("glitch_locked", int'(bus.locked), 0);
    chk("glitch_period", int'(bus.period), 16);

    // Asynchronous reset while in NEG
    do_reset();
    for (int c = 0; c < 2; c++) begin
      half(20000, 50);
      half(-20000, 50);
    end
    put(20000);
    half(20000, 49);
    half(-20000, 20);
    idle(1);
    chk("arst_pre_env_up", int'(bus.env_up), 20000);
    chk("arst_pre_state",  int'(dut.state),  int'(NEG));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_env_up",    int'(bus.env_up),    0);
    chk("arst_env_down",  int'(bus.env_down),  0);
    chk("arst_period",    int'(bus.period),    0);
    chk("arst_env_valid", int'(bus.env_valid), 0);
    chk("arst_state",     int'(dut.state),     int'(SEEK));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // 30-clock gap of invalid (garbage) samples mid-cycle
    p0 = pulses;
    half(20000, 25);
    repeat (30) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample       = 16'(-30000 + 32768);
    end
    half(20000, 25);
    half(-20000, 50);
    put(20000);
    idle(2);
    chk("gap_pulses",   pulses - p0,        1);
    chk("gap_period",   int'(bus.period),   100);
    chk("gap_env_down", int'(bus.env_down), 20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
